// File: rtl/alu_fctn_encoder_if.sv
// Request/relay bus between the ALU op sequencer and the function-code encoder.
// The master presents one-hot requests; the slave drives the relay code and status.
interface alu_fctn_encoder_if;
    logic       op_valid;
    logic [7:0] op_onehot;
    logic       op_ready;
    logic [2:0] fctn_code;
    logic       fctn_strobe;
    logic       done;
    logic       err;

    modport master (
        output op_valid,
        output op_onehot,
        input  op_ready,
        input  fctn_code,
        input  fctn_strobe,
        input  done,
        input  err
    );

    modport slave (
        input  op_valid,
        input  op_onehot,
        output op_ready,
        output fctn_code,
        output fctn_strobe,
        output done,
        output err
    );
endinterface

// File: rtl/alu_fctn_encoder.sv
// Encodes a one-hot ALU operation into a 3-bit relay function code and holds it
// on the relay bus for SETTLE_CYCLES cycles, then pulses done.
module alu_fctn_encoder #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_fctn_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD  = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] CODE_NULL = 3'b111;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] code_p1, code_nxt;
    logic       err_p1, err_nxt;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Bit 7 (ADD) maps to code 0, bit 0 (NULL) maps to code 7.
    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] c;
        c = CODE_NULL;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) c = 3'(7 - i);
        end
        return c;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_p1;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.op_valid) begin
                    if (is_onehot(bus.op_onehot)) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = CNT_LOAD;
                        code_nxt  = encode(bus.op_onehot);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            err_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            err_p1 <= err_nxt;
        end
    end

    // Code register needs no reset: it is only visible outside IDLE.
    always_ff @(posedge clk) begin
        code_p1 <= code_nxt;
    end

    assign bus.op_ready    = (state == IDLE) && !reset;
    assign bus.fctn_strobe = (state != IDLE);
    assign bus.fctn_code   = (state == IDLE) ? CODE_NULL : code_p1;
    assign bus.done        = (state == DONE) && !reset;
    assign bus.err         = err_p1 && !reset;

endmodule
